vsd_caravel: RTL and testbench
==============================

VSD_CARAVEL -- requirements
Module: vsd_caravel

Interface
REQ-001 SHALL have parameter MFG_ID, default 12'h456, manufacturer ID exposed in registers 0x01/0x02.
REQ-002 SHALL have parameter PRODUCT_ID, default 8'h11, product ID exposed in register 0x03.
REQ-003 SHALL have parameter USER_ID, default 32'h0, user project ID exposed in registers 0x04-0x07 (MSB first).
REQ-004 clock  input  1  system clock (40 MHz nominal); one clock, sole clock of all flops.
REQ-005 resetb  input  1  reset, asynchronous, active-low.
REQ-006 mprj_io  inout  38  [4]=SCK in, [3]=CSB in, [2]=SDI in, [1]=SDO out, [6]=UART TX out, all others high-Z.
REQ-007 gpio  inout  1  management GPIO; high-Z.
REQ-008 flash_csb / flash_clk  output  1 each  SPI flash select/clock; idle 1 / 0.
REQ-009 flash_io0 / flash_io1  inout  1 each  flash data; high-Z.
REQ-010 vddio, vddio_2, vssio, vssio_2, vdda, vssa, vccd, vssd, vdda1, vdda1_2, vdda2, vssa1, vssa1_2, vssa2, vccd1, vccd2, vssd1, vssd2  inout  1 each  power pins; no logic function.

Function
REQ-011 SCK, CSB, SDI SHALL be synchronized to clock via 2-flop synchronizers; SCK edges detected from synchronized samples.
REQ-012 SPI mode 0, MSB first; SDI sampled on detected SCK rise; CSB high aborts any transaction and returns to IDLE.
REQ-013 FSM states: IDLE -> CMD (8 bits) -> ADDR (8 bits) -> DATA (repeating 8-bit bytes) until CSB high.
REQ-014 Command byte: bit7=write, bit6=read, bits[5:3]=byte count N (0 = streaming, unlimited); command 0x00 ignores remaining bytes.
REQ-015 Address auto-increments by 1 after each data byte, 8-bit wrap 0xFF->0x00; transfer ends after N bytes when N!=0.
REQ-016 Read: on the SCK rise completing the last address bit (or a data byte) SDO SHALL load bit7 of register[addr]; each subsequent rise shifts the next bit; SDO valid within 3 clocks of the rise and held until the next rise.
REQ-017 SDO (mprj_io[1]) SHALL be driven only while synchronized CSB is low and a read is active; otherwise high-Z.
REQ-018 Write: byte committed to register[addr] on 8th data-bit rise; writes to read-only or unmapped addresses ignored.
REQ-019 Read/write command 0xC0: shifted-out byte is the pre-write register value.
REQ-020 Register map (read value): 0x00 status=0x00 RO; 0x01={4'h0,MFG_ID[11:8]} RO; 0x02=MFG_ID[7:0] RO; 0x03=PRODUCT_ID RO; 0x04-0x07=USER_ID bytes RO; 0x08 PLL enable RW [1:0]; 0x09 PLL bypass RW [0]; 0x0A IRQ RW [0]; 0x0B ext reset RW [0]; 0x0C trap status RO=0x00; 0x0D-0x10 PLL trim[25:0] RW, LSB byte first; 0x11 PLL sel RW [5:0]; 0x12 PLL div RW [4:0]; others read 0x00.
REQ-021 Unimplemented register bits SHALL read 0.
REQ-022 While reg 0x0B[0]=1 the internal core is held in reset: flash_csb=1, flash_clk=0, UART TX=1; housekeeping registers unaffected.
REQ-023 mprj_io[6] SHALL drive 1 (UART idle).

Reset
REQ-024 On resetb low: FSM IDLE, SDO high-Z, reg 0x08=0x02, 0x09=0x01, 0x0A=0x00, 0x0B=0x00, trim=26'h3FFEFFF (0x0D=0xFF,0x0E=0xEF,0x0F=0xFF,0x10=0x03), 0x11=0x12, 0x12=0x04.
REQ-025 Reset mid-transaction SHALL abort it with no partial register write.

Structure
REQ-026 Package vsd_caravel_pkg SHALL hold register addresses, reset values, command bit positions and FSM state enum.
REQ-027 SPI slave + register file SHALL be sub-module vsd_hk_spi; top vsd_caravel handles pad mapping and tri-states.

Verification
REQ-028 Reset, then CSB low, send 0x40, 0x03, read one byte -> 0x11.
REQ-029 Stream read 0x40, 0x00, 19 bytes -> 00 04 56 11 00 00 00 00 02 01 00 00 00 FF EF FF 03 12 04.
REQ-030 Write 0x80, 0x0B, 0x01 -> flash_csb stays 1, readback 0x01; write 0x00 -> readback 0x00.
REQ-031 Write 0x80, 0x03, 0xAA -> readback of 0x03 still 0x11; write 0x80, 0x12, 0x1F -> readback 0x1F.
REQ-032 Raise CSB mid-byte during write, then read address -> unchanged value; SDO high-Z while CSB high.
REQ-033 Command 0x48 (N=1), 0x02, clock 2 bytes -> first byte 0x56, SDO high-Z for second byte.

Source files
------------

// File: rtl/vsd_caravel_pkg.sv
// Shared definitions for the Caravel housekeeping SPI: register map, reset values,
// command byte layout and the SPI slave state encoding.
package vsd_caravel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } hk_state_e;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_RD_BIT = 6;
  localparam int CMD_N_MSB  = 5;
  localparam int CMD_N_LSB  = 3;

  localparam logic [7:0] ADDR_STATUS     = 8'h00;
  localparam logic [7:0] ADDR_MFG_HI     = 8'h01;
  localparam logic [7:0] ADDR_MFG_LO     = 8'h02;
  localparam logic [7:0] ADDR_PRODUCT    = 8'h03;
  localparam logic [7:0] ADDR_USER0      = 8'h04;
  localparam logic [7:0] ADDR_USER1      = 8'h05;
  localparam logic [7:0] ADDR_USER2      = 8'h06;
  localparam logic [7:0] ADDR_USER3      = 8'h07;
  localparam logic [7:0] ADDR_PLL_ENA    = 8'h08;
  localparam logic [7:0] ADDR_PLL_BYPASS = 8'h09;
  localparam logic [7:0] ADDR_IRQ        = 8'h0A;
  localparam logic [7:0] ADDR_EXT_RESET  = 8'h0B;
  localparam logic [7:0] ADDR_TRAP       = 8'h0C;
  localparam logic [7:0] ADDR_TRIM0      = 8'h0D;
  localparam logic [7:0] ADDR_TRIM1      = 8'h0E;
  localparam logic [7:0] ADDR_TRIM2      = 8'h0F;
  localparam logic [7:0] ADDR_TRIM3      = 8'h10;
  localparam logic [7:0] ADDR_PLL_SEL    = 8'h11;
  localparam logic [7:0] ADDR_PLL_DIV    = 8'h12;

  localparam logic [1:0]  RST_PLL_ENA    = 2'b10;
  localparam logic        RST_PLL_BYPASS = 1'b1;
  localparam logic        RST_IRQ        = 1'b0;
  localparam logic        RST_EXT_RESET  = 1'b0;
  localparam logic [25:0] RST_PLL_TRIM   = 26'h3FFEFFF;
  localparam logic [5:0]  RST_PLL_SEL    = 6'h12;
  localparam logic [4:0]  RST_PLL_DIV    = 5'h04;

  function automatic logic [2:0] cmd_count(input logic [7:0] cmd);
    return cmd[CMD_N_MSB:CMD_N_LSB];
  endfunction

endpackage

// File: rtl/vsd_hk_spi.sv
// Housekeeping SPI slave (mode 0, MSB first) with its register file; all SPI pins
// are oversampled by clk through 2-flop synchronizers.
//
// state   | meaning
// IDLE    | CSB high (or just fell); counters cleared
// CMD     | shifting in command byte
// ADDR    | shifting in address byte; read data preloaded on its last bit
// DATA    | data bytes; stays here after a counted transfer ends until CSB rises
module vsd_hk_spi
  import vsd_caravel_pkg::*;
#(
  parameter logic [11:0] MFG_ID     = 12'h456,
  parameter logic [7:0]  PRODUCT_ID = 8'h11,
  parameter logic [31:0] USER_ID    = 32'h0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sck,
  input  logic i_csb,
  input  logic i_sdi,
  output logic o_sdo,
  output logic o_sdo_oe
);

  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_csb_meta, r_csb_sync;
  logic r_sdi_meta, r_sdi_sync;

  hk_state_e r_state, w_state_nxt;

  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift_in;
  logic [7:0]  r_sdo_shift;
  logic [7:0]  r_addr;
  logic [2:0]  r_remaining;
  logic        r_stream;
  logic        r_wr_en;
  logic        r_rd_en;
  logic        r_xfer_active;

  logic [1:0]  r_pll_ena;
  logic        r_pll_bypass;
  logic        r_irq;
  logic        r_ext_reset;
  logic [25:0] r_pll_trim;
  logic [5:0]  r_pll_sel;
  logic [4:0]  r_pll_div;

  logic        w_sck_rise;
  logic        w_byte_done;
  logic [7:0]  w_byte;
  logic [7:0]  w_addr_inc;
  logic [7:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic        w_more;
  logic        w_wr_commit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_csb_meta <= 1'b1;
      r_csb_sync <= 1'b1;
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sck_meta <= i_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_csb_meta <= i_csb;
      r_csb_sync <= r_csb_meta;
      r_sdi_meta <= i_sdi;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  // SDI travels the same synchronizer depth as SCK, so r_sdi_sync is the bit at the rise.
  assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_byte      = {r_shift_in[6:0], r_sdi_sync};
  assign w_addr_inc  = r_addr + 8'd1;
  assign w_rd_addr   = (r_state == ST_ADDR) ? w_byte : w_addr_inc;
  assign w_more      = r_stream || (r_remaining != 3'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_csb_sync) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_CMD;
        ST_CMD:  if (w_sck_rise && w_byte_done) w_state_nxt = ST_ADDR;
        ST_ADDR: if (w_sck_rise && w_byte_done) w_state_nxt = ST_DATA;
        ST_DATA: w_state_nxt = ST_DATA;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt     <= 3'd0;
      r_shift_in    <= 8'h00;
      r_sdo_shift   <= 8'h00;
      r_addr        <= 8'h00;
      r_remaining   <= 3'd0;
      r_stream      <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_xfer_active <= 1'b0;
    end else if (r_csb_sync || (r_state == ST_IDLE)) begin
      r_bit_cnt     <= 3'd0;
      r_shift_in    <= 8'h00;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_xfer_active <= 1'b0;
    end else if (w_sck_rise) begin
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      r_shift_in <= w_byte;
      case (r_state)
        ST_CMD: begin
          if (w_byte_done) begin
            r_wr_en     <= w_byte[CMD_WR_BIT];
            r_rd_en     <= w_byte[CMD_RD_BIT];
            r_remaining <= cmd_count(w_byte);
            r_stream    <= (cmd_count(w_byte) == 3'd0);
          end
        end
        ST_ADDR: begin
          if (w_byte_done) begin
            r_addr        <= w_byte;
            r_xfer_active <= 1'b1;
            if (r_rd_en) r_sdo_shift <= w_rd_data;
          end
        end
        ST_DATA: begin
          if (r_xfer_active) begin
            r_sdo_shift <= {r_sdo_shift[6:0], 1'b0};
            if (w_byte_done) begin
              r_addr <= w_addr_inc;
              if (!r_stream) begin
                r_remaining <= r_remaining - 3'd1;
                if (r_remaining == 3'd1) r_xfer_active <= 1'b0;
              end
              if (r_rd_en && w_more) r_sdo_shift <= w_rd_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The shifted-out byte was loaded before this commit, so read/write returns the old value.
  assign w_wr_commit = w_sck_rise & ~r_csb_sync & (r_state == ST_DATA) &
                       r_xfer_active & r_wr_en & w_byte_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pll_ena    <= RST_PLL_ENA;
      r_pll_bypass <= RST_PLL_BYPASS;
      r_irq        <= RST_IRQ;
      r_ext_reset  <= RST_EXT_RESET;
      r_pll_trim   <= RST_PLL_TRIM;
      r_pll_sel    <= RST_PLL_SEL;
      r_pll_div    <= RST_PLL_DIV;
    end else if (w_wr_commit) begin
      case (r_addr)
        ADDR_PLL_ENA:    r_pll_ena          <= w_byte[1:0];
        ADDR_PLL_BYPASS: r_pll_bypass       <= w_byte[0];
        ADDR_IRQ:        r_irq              <= w_byte[0];
        ADDR_EXT_RESET:  r_ext_reset        <= w_byte[0];
        ADDR_TRIM0:      r_pll_trim[7:0]    <= w_byte;
        ADDR_TRIM1:      r_pll_trim[15:8]   <= w_byte;
        ADDR_TRIM2:      r_pll_trim[23:16]  <= w_byte;
        ADDR_TRIM3:      r_pll_trim[25:24]  <= w_byte[1:0];
        ADDR_PLL_SEL:    r_pll_sel          <= w_byte[5:0];
        ADDR_PLL_DIV:    r_pll_div          <= w_byte[4:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      ADDR_STATUS:     w_rd_data = 8'h00;
      ADDR_MFG_HI:     w_rd_data = {4'h0, MFG_ID[11:8]};
      ADDR_MFG_LO:     w_rd_data = MFG_ID[7:0];
      ADDR_PRODUCT:    w_rd_data = PRODUCT_ID;
      ADDR_USER0:      w_rd_data = USER_ID[31:24];
      ADDR_USER1:      w_rd_data = USER_ID[23:16];
      ADDR_USER2:      w_rd_data = USER_ID[15:8];
      ADDR_USER3:      w_rd_data = USER_ID[7:0];
      ADDR_PLL_ENA:    w_rd_data = {6'd0, r_pll_ena};
      ADDR_PLL_BYPASS: w_rd_data = {7'd0, r_pll_bypass};
      ADDR_IRQ:        w_rd_data = {7'd0, r_irq};
      ADDR_EXT_RESET:  w_rd_data = {7'd0, r_ext_reset};
      ADDR_TRAP:       w_rd_data = 8'h00;
      ADDR_TRIM0:      w_rd_data = r_pll_trim[7:0];
      ADDR_TRIM1:      w_rd_data = r_pll_trim[15:8];
      ADDR_TRIM2:      w_rd_data = r_pll_trim[23:16];
      ADDR_TRIM3:      w_rd_data = {6'd0, r_pll_trim[25:24]};
      ADDR_PLL_SEL:    w_rd_data = {2'd0, r_pll_sel};
      ADDR_PLL_DIV:    w_rd_data = {3'd0, r_pll_div};
      default:         w_rd_data = 8'h00;
    endcase
  end

  assign o_sdo    = r_sdo_shift[7];
  assign o_sdo_oe = ~r_csb_sync & r_rd_en & r_xfer_active & (r_state == ST_DATA);

endmodule

// File: rtl/vsd_caravel.sv
// Caravel chip top: maps the housekeeping SPI onto mprj_io and parks every other pad.
// No management core is integrated, so flash and UART pads sit at their held-in-reset levels.
module vsd_caravel
  import vsd_caravel_pkg::*;
#(
  parameter logic [11:0] MFG_ID     = 12'h456,
  parameter logic [7:0]  PRODUCT_ID = 8'h11,
  parameter logic [31:0] USER_ID    = 32'h0
) (
  inout  wire         vddio,
  inout  wire         vddio_2,
  inout  wire         vssio,
  inout  wire         vssio_2,
  inout  wire         vdda,
  inout  wire         vssa,
  inout  wire         vccd,
  inout  wire         vssd,
  inout  wire         vdda1,
  inout  wire         vdda1_2,
  inout  wire         vdda2,
  inout  wire         vssa1,
  inout  wire         vssa1_2,
  inout  wire         vssa2,
  inout  wire         vccd1,
  inout  wire         vccd2,
  inout  wire         vssd1,
  inout  wire         vssd2,
  inout  wire         gpio,
  inout  wire  [37:0] mprj_io,
  output logic        flash_csb,
  output logic        flash_clk,
  inout  wire         flash_io0,
  inout  wire         flash_io1,
  input  logic        clock,
  input  logic        resetb
);

  logic w_sdo;
  logic w_sdo_oe;

  vsd_hk_spi #(
    .MFG_ID     (MFG_ID),
    .PRODUCT_ID (PRODUCT_ID),
    .USER_ID    (USER_ID)
  ) u_hk_spi (
    .i_clk    (clock),
    .i_rst_n  (resetb),
    .i_sck    (mprj_io[4]),
    .i_csb    (mprj_io[3]),
    .i_sdi    (mprj_io[2]),
    .o_sdo    (w_sdo),
    .o_sdo_oe (w_sdo_oe)
  );

  // mprj_io[4:2] are pure inputs and deliberately left undriven here.
  assign mprj_io[0]    = 1'bz;
  assign mprj_io[1]    = w_sdo_oe ? w_sdo : 1'bz;
  assign mprj_io[5]    = 1'bz;
  assign mprj_io[6]    = 1'b1;
  assign mprj_io[37:7] = {31{1'bz}};

  assign gpio      = 1'bz;
  assign flash_io0 = 1'bz;
  assign flash_io1 = 1'bz;
  assign flash_csb = 1'b1;
  assign flash_clk = 1'b0;

endmodule

// File: tb/tb_vsd_caravel.sv
// Scoreboard bench for vsd_caravel: SPI driver pushes expected bytes, a monitor
// pops and compares each byte the driver captures from SDO.
module tb_vsd_caravel;

  localparam int HALF = 8;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic r_sck = 1'b0;
  logic r_csb = 1'b1;
  logic r_sdi = 1'b0;

  wire [37:0] mprj_io;
  wire gpio, flash_io0, flash_io1;
  wire flash_csb, flash_clk;
  wire vddio, vddio_2, vssio, vssio_2, vdda, vssa, vccd, vssd;
  wire vdda1, vdda1_2, vdda2, vssa1, vssa1_2, vssa2, vccd1, vccd2, vssd1, vssd2;

  assign mprj_io[4] = r_sck;
  assign mprj_io[3] = r_csb;
  assign mprj_io[2] = r_sdi;
  pullup pu_sdo (mprj_io[1]);

  vsd_caravel dut (
    .vddio(vddio), .vddio_2(vddio_2), .vssio(vssio), .vssio_2(vssio_2),
    .vdda(vdda), .vssa(vssa), .vccd(vccd), .vssd(vssd),
    .vdda1(vdda1), .vdda1_2(vdda1_2), .vdda2(vdda2), .vssa1(vssa1),
    .vssa1_2(vssa1_2), .vssa2(vssa2), .vccd1(vccd1), .vccd2(vccd2),
    .vssd1(vssd1), .vssd2(vssd2),
    .gpio(gpio), .mprj_io(mprj_io),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1),
    .clock(clock), .resetb(resetb)
  );

  always #5 clock = ~clock;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] act_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // Pin-level observation routed through the same scoreboard.
  task automatic chk_pin(input string nm, input logic exp_v, input logic act_v);
    expect_byte(nm, {7'd0, exp_v});
    act_q.push_back({7'd0, act_v});
  endtask

  task automatic spi_bit(input logic b, output logic r);
    r_sdi = b;
    wait_clk(HALF);
    r = mprj_io[1];
    r_sck = 1'b1;
    wait_clk(HALF);
    r_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_begin();
    r_csb = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    wait_clk(4);
    r_csb = 1'b1;
    wait_clk(8);
  endtask

  task automatic rd_stream(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic [7:0] rx;
    cs_begin();
    spi_byte(cmd, rx);
    spi_byte(addr, rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      act_q.push_back(rx);
    end
    cs_end();
  endtask

  task automatic rd1(input string nm, input logic [7:0] addr, input logic [7:0] v);
    expect_byte(nm, v);
    rd_stream(8'h40, addr, 1);
  endtask

  task automatic wr1(input logic [7:0] addr, input logic [7:0] v);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h80, rx);
    spi_byte(addr, rx);
    spi_byte(v, rx);
    cs_end();
  endtask

  initial begin : monitor
    logic [7:0] a, e;
    string nm;
    forever begin
      @(posedge clock);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_output: got %02h with no expected value queued", a);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", nm, a, e);
          end
        end
      end
    end
  end

  logic [7:0] exp19 [19] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF,
                             8'h03, 8'h12, 8'h04};

  initial begin : stim
    logic [7:0] rx;
    logic b;
    wait_clk(5);
    resetb = 1'b1;
    wait_clk(5);

    chk_pin("rst_flash_csb", 1'b1, flash_csb);
    chk_pin("rst_flash_clk", 1'b0, flash_clk);
    chk_pin("rst_uart_tx", 1'b1, mprj_io[6]);
    chk_pin("rst_sdo_z", 1'b1, mprj_io[1]);

    rd1("rd_product", 8'h03, 8'h11);

    for (int i = 0; i < 19; i++) expect_byte($sformatf("stream_%0d", i), exp19[i]);
    rd_stream(8'h40, 8'h00, 19);

    wr1(8'h0B, 8'h01);
    chk_pin("extrst_flash_csb", 1'b1, flash_csb);
    chk_pin("extrst_flash_clk", 1'b0, flash_clk);
    chk_pin("extrst_uart_tx", 1'b1, mprj_io[6]);
    rd1("rd_extrst_1", 8'h0B, 8'h01);
    wr1(8'h0B, 8'h00);
    rd1("rd_extrst_0", 8'h0B, 8'h00);

    wr1(8'h03, 8'hAA);
    rd1("rd_product_ro", 8'h03, 8'h11);
    wr1(8'h12, 8'h1F);
    rd1("rd_pll_div", 8'h12, 8'h1F);

    // Abort a write to 0x12 after four data bits.
    cs_begin();
    spi_byte(8'h80, rx);
    spi_byte(8'h12, rx);
    for (int i = 0; i < 4; i++) spi_bit(i[0], b);
    wait_clk(4);
    r_csb = 1'b1;
    wait_clk(8);
    chk_pin("abort_sdo_z", 1'b1, mprj_io[1]);
    rd1("rd_after_abort", 8'h12, 8'h1F);

    // Streaming read stopped by CSB: SDO driven (bit7 of 0x11 = 0), then released.
    expect_byte("stream_cut_byte", 8'h56);
    cs_begin();
    spi_byte(8'h40, rx);
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    act_q.push_back(rx);
    wait_clk(4);
    chk_pin("sdo_driven_low", 1'b0, mprj_io[1]);
    r_csb = 1'b1;
    wait_clk(8);
    chk_pin("csb_high_sdo_z", 1'b1, mprj_io[1]);

    expect_byte("n1_byte0", 8'h56);
    expect_byte("n1_byte1_z", 8'hFF);
    rd_stream(8'h48, 8'h02, 2);

    expect_byte("rw_prewrite", 8'h12);
    cs_begin();
    spi_byte(8'hC0, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h2A, rx);
    act_q.push_back(rx);
    cs_end();
    rd1("rd_pll_sel", 8'h11, 8'h2A);

    wr1(8'h08, 8'hFF);
    rd1("rd_pll_ena_mask", 8'h08, 8'h03);

    cs_begin();
    spi_byte(8'h80, rx);
    spi_byte(8'h0D, rx);
    spi_byte(8'h12, rx);
    spi_byte(8'h34, rx);
    spi_byte(8'h56, rx);
    spi_byte(8'hFF, rx);
    cs_end();
    expect_byte("trim0", 8'h12);
    expect_byte("trim1", 8'h34);
    expect_byte("trim2", 8'h56);
    expect_byte("trim3", 8'h03);
    rd_stream(8'h40, 8'h0D, 4);

    cs_begin();
    spi_byte(8'h88, rx);
    spi_byte(8'h09, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h01, rx);
    cs_end();
    expect_byte("nlim_bypass", 8'h00);
    expect_byte("nlim_irq", 8'h00);
    rd_stream(8'h40, 8'h09, 2);

    expect_byte("wrap_ff", 8'h00);
    expect_byte("wrap_00", 8'h00);
    expect_byte("wrap_01", 8'h04);
    rd_stream(8'h40, 8'hFF, 3);

    // Reset in the middle of a write to 0x12.
    cs_begin();
    spi_byte(8'h80, rx);
    spi_byte(8'h12, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    resetb = 1'b0;
    r_sck = 1'b0;
    r_csb = 1'b1;
    wait_clk(5);
    resetb = 1'b1;
    wait_clk(8);
    rd1("rst_pll_div", 8'h12, 8'h04);
    rd1("rst_pll_sel", 8'h11, 8'h12);
    rd1("rst_pll_ena", 8'h08, 8'h02);

    for (int i = 0; i < 200 && act_q.size() > 0; i++) wait_clk(1);
    if (act_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d captured bytes left, required 0", act_q.size());
    end
    while (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no output, expected %02h", name_q.pop_front(), exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
